// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: turns single-cycle MEM-stage load/store requests into
// byte-lane-aligned transactions on a ready-handshaked memory/MMIO bus,
// stalling the pipeline until the bus answers.
//
// Optional feature: define MEM_BUS_BRIDGE_TIMEOUT_EN to abort a bus access
// that waits TIMEOUT cycles without bus_ready (cpu_err pulses, read data 0).
// Without it, BUSY waits for bus_ready indefinitely.

module mem_bus_bridge #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_dm_ctrl,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic        req;
    logic        aligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;

`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
    logic [7:0]  wait_cnt;
`endif

    assign req = cpu_rd | cpu_wr;

    // Decode the access width into alignment, byte enables and replicated write data
    always_comb begin
        aligned    = 1'b1;
        lane_be    = 4'b1111;
        lane_wdata = cpu_wdata;
        case (cpu_dm_ctrl)
            3'b001, 3'b010: begin
                aligned    = ~cpu_addr[0];
                lane_be    = cpu_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{cpu_wdata[15:0]}};
            end
            3'b011, 3'b100: begin
                aligned    = 1'b1;
                lane_be    = 4'b0001 << cpu_addr[1:0];
                lane_wdata = {4{cpu_wdata[7:0]}};
            end
            default: begin
                aligned    = (cpu_addr[1:0] == 2'b00);
                lane_be    = 4'b1111;
                lane_wdata = cpu_wdata;
            end
        endcase
    end

    // Stall while a bus access is being launched or is outstanding; a misaligned
    // request never stalls because it never reaches the bus
    always_comb begin
        cpu_stall = (state == BUSY) || ((state == IDLE) && req && aligned);
    end

    // Transaction FSM with registered bus/CPU outputs; reset abandons any access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_be    <= 4'h0;
            bus_wdata <= 32'h0;
            cpu_rdata <= 32'h0;
            cpu_err   <= 1'b0;
`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
            wait_cnt  <= 8'h0;
`endif
        end else begin
            cpu_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (aligned) begin
                            bus_req   <= 1'b1;
                            bus_we    <= cpu_wr;
                            bus_addr  <= {cpu_addr[31:2], 2'b00};
                            bus_be    <= lane_be;
                            bus_wdata <= lane_wdata;
`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
                            wait_cnt  <= 8'h0;
`endif
                            state     <= BUSY;
                        end else begin
                            cpu_err <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (bus_ready) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            cpu_rdata <= bus_rdata;
                        end
                        state <= DONE;
                    end
`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT) begin
                        bus_req   <= 1'b0;
                        cpu_rdata <= 32'h0;
                        cpu_err   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
